// File: rtl/clock_pkg.sv
// Shared types and default moduli for the countdown timer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_pkg;

  // Timer control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Default field moduli (seconds, minutes, hours).
  localparam int DEF_SEC_LIMIT  = 60;
  localparam int DEF_MIN_LIMIT  = 60;
  localparam int DEF_HOUR_LIMIT = 24;

endpackage

// File: rtl/countdown_timer_down_counter.sv
// DownCounter: one modulo-LIMIT field of the countdown with load clamping.
// Latency: value updates on the edge after iEn/iLoad; oBorrow/oZero are combinational.
// Backpressure: none; iEn is a strobe and every asserted cycle counts.
//
// Ports:
//   iClk, iRst   clock, async active-low reset (value -> 0)
//   iEn          decrement this field this cycle
//   iLoad        load iValue (clamped to LIMIT-1), wins over iEn
//   iValue       load value
//   oValue       registered field value
//   oBorrow      iEn while value is 0: this decrement wraps, borrow from next field
//   oZero        value is 0
module DownCounter #(
  parameter int LIMIT = 60,
  parameter int W     = 6
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iEn,
  input  logic         iLoad,
  input  logic [W-1:0] iValue,
  output logic [W-1:0] oValue,
  output logic         oBorrow,
  output logic         oZero
);

  localparam logic [W-1:0] MAX_VAL = W'(LIMIT - 1);

  logic [W-1:0] r_value;
  logic [W-1:0] w_load_val;

  // Out-of-range load values saturate to the top of the field.
  assign w_load_val = (32'(iValue) >= LIMIT) ? MAX_VAL : iValue;

  assign oZero   = (r_value == '0);
  assign oBorrow = iEn & oZero;
  assign oValue  = r_value;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_value <= '0;
    end else if (iLoad) begin
      r_value <= w_load_val;
    end else if (iEn) begin
      r_value <= oZero ? MAX_VAL : (r_value - 1'b1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: hh:mm:ss down-counter with IDLE/RUN/PAUSE/EXPIRED control.
// Latency: count, state flags and oDone update on the edge after the request/tick.
// Backpressure: none; every iTick cycle in RUN decrements, requests resolve same cycle.
//
// Ports:
//   iClk, iRst            clock, async active-low reset
//   iTick                 count-enable strobe (1 Hz in system)
//   iLoad, iHour/iMin/iSec load count (clamped per field), go IDLE
//   iStart, iStop         run / pause-or-acknowledge requests
//   oHour/oMin/oSec       registered count
//   oRunning              high in RUN
//   oDone                 one-cycle pulse when the count reaches 00:00:00
//   oAlarm                latched expiry; only live when COUNTDOWN_ALARM_EN is defined,
//                         otherwise tied 0
module countdown_timer
  import clock_pkg::*;
#(
  parameter int SEC_LIMIT  = DEF_SEC_LIMIT,
  parameter int MIN_LIMIT  = DEF_MIN_LIMIT,
  parameter int HOUR_LIMIT = DEF_HOUR_LIMIT
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTick,
  input  logic       iLoad,
  input  logic [5:0] iSec,
  input  logic [5:0] iMin,
  input  logic [4:0] iHour,
  input  logic       iStart,
  input  logic       iStop,
  output logic [5:0] oSec,
  output logic [5:0] oMin,
  output logic [4:0] oHour,
  output logic       oRunning,
  output logic       oDone,
  output logic       oAlarm
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_running;
  logic   r_done;

  logic [5:0] w_sec;
  logic [5:0] w_min;
  logic [4:0] w_hour;
  logic       w_sec_borrow, w_min_borrow, w_hour_borrow;
  logic       w_sec_zero, w_min_zero, w_hour_zero;
  logic       w_all_zero;
  logic       w_dec;
  logic       w_expire;

  assign w_all_zero = w_sec_zero & w_min_zero & w_hour_zero;

  // A tick only counts in RUN when no higher-priority request is present.
  // The all-zero guard keeps the chain from ever wrapping out of 00:00:00.
  assign w_dec = (r_state == ST_RUN) & iTick & ~iLoad & ~iStop & ~w_all_zero;

  // The decrement that lands on 00:00:00 is the one taken from 00:00:01.
  assign w_expire = w_dec & (w_sec == 6'd1) & w_min_zero & w_hour_zero;

  DownCounter #(.LIMIT(SEC_LIMIT), .W(6)) u_sec (
    .iClk    (iClk),
    .iRst    (iRst),
    .iEn     (w_dec),
    .iLoad   (iLoad),
    .iValue  (iSec),
    .oValue  (w_sec),
    .oBorrow (w_sec_borrow),
    .oZero   (w_sec_zero)
  );

  DownCounter #(.LIMIT(MIN_LIMIT), .W(6)) u_min (
    .iClk    (iClk),
    .iRst    (iRst),
    .iEn     (w_sec_borrow),
    .iLoad   (iLoad),
    .iValue  (iMin),
    .oValue  (w_min),
    .oBorrow (w_min_borrow),
    .oZero   (w_min_zero)
  );

  DownCounter #(.LIMIT(HOUR_LIMIT), .W(5)) u_hour (
    .iClk    (iClk),
    .iRst    (iRst),
    .iEn     (w_min_borrow),
    .iLoad   (iLoad),
    .iValue  (iHour),
    .oValue  (w_hour),
    .oBorrow (w_hour_borrow),
    .oZero   (w_hour_zero)
  );

  // An hour borrow would mean wrapping below zero; the w_dec guard rules it out.
  a_no_wrap : assert property (@(posedge iClk) disable iff (!iRst) !w_hour_borrow);

  always_comb begin
    w_state_nxt = r_state;
    if (iLoad) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          // A start on a zero count is dropped: nothing to run, nothing to expire.
          if (iStart && !w_all_zero) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (iStop)         w_state_nxt = ST_PAUSE;
          else if (w_expire) w_state_nxt = ST_EXPIRED;
        end
        ST_EXPIRED: begin
          if (iStop) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= w_expire;
    end
  end

`ifdef COUNTDOWN_ALARM_EN
  logic r_alarm;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_alarm <= 1'b0;
    end else if (iLoad || iStop) begin
      r_alarm <= 1'b0;
    end else if (w_expire) begin
      r_alarm <= 1'b1;
    end
  end

  assign oAlarm = r_alarm;
`else
  assign oAlarm = 1'b0;
`endif

  assign oSec     = w_sec;
  assign oMin     = w_min;
  assign oHour    = w_hour;
  assign oRunning = r_running;
  assign oDone    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: load/start/tick/stop scenarios with hand-computed counts.
// Latency: checks sampled 1 time unit after the rising edge that consumes the stimulus.
// Backpressure: n/a; a time-limit watchdog ends a stuck run.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, load, start, stop;
  logic [5:0] sec_in, min_in;
  logic [4:0] hour_in;
  logic [5:0] sec_o, min_o;
  logic [4:0] hour_o;
  logic       running, done, alarm;

  int n_vec = 0;
  int n_err = 0;

`ifdef COUNTDOWN_ALARM_EN
  localparam logic ALARM_ON_EXPIRE = 1'b1;
`else
  localparam logic ALARM_ON_EXPIRE = 1'b0;
`endif

  always #5 clk = ~clk;

  countdown_timer dut (
    .iClk     (clk),
    .iRst     (rst_n),
    .iTick    (tick),
    .iLoad    (load),
    .iSec     (sec_in),
    .iMin     (min_in),
    .iHour    (hour_in),
    .iStart   (start),
    .iStop    (stop),
    .oSec     (sec_o),
    .oMin     (min_o),
    .oHour    (hour_o),
    .oRunning (running),
    .oDone    (done),
    .oAlarm   (alarm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hour_in = h; min_in = m; sec_in = s; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick = 0; load = 0; start = 0; stop = 0;
    sec_in = 6'd17; min_in = 6'd3; hour_in = 5'd2;
    #12;
    n_vec++;
    if ({hour_o, min_o, sec_o} !== 17'd0) begin
      n_err++; $display("FAIL reset_count got %0d:%0d:%0d want 0:0:0", hour_o, min_o, sec_o);
    end
    n_vec++;
    if ({running, done, alarm} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got run/done/alarm=%b want 000", {running, done, alarm});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sec_borrow();
    do_load(5'd0, 6'd1, 6'd5);
    n_vec++;
    if ({hour_o, min_o, sec_o, running} !== {5'd0, 6'd1, 6'd5, 1'b0}) begin
      n_err++; $display("FAIL load_0105 got %0d:%0d:%0d run=%b want 0:1:5 run=0", hour_o, min_o, sec_o, running);
    end
    do_start();
    n_vec++;
    if (running !== 1'b1) begin
      n_err++; $display("FAIL start_running got %b want 1", running);
    end
    // Tick held high for 6 cycles: 05,04,03,02,01,00 -> borrow -> 00:00:59.
    do_ticks(6);
    n_vec++;
    if ({hour_o, min_o, sec_o, running} !== {5'd0, 6'd0, 6'd59, 1'b1}) begin
      n_err++; $display("FAIL sec_borrow got %0d:%0d:%0d run=%b want 0:0:59 run=1", hour_o, min_o, sec_o, running);
    end
  endtask

  task automatic test_expire();
    int pulses;
    do_load(5'd0, 6'd0, 6'd2);
    do_start();
    do_ticks(1);
    n_vec++;
    if ({sec_o, done} !== {6'd1, 1'b0}) begin
      n_err++; $display("FAIL expire_first got sec=%0d done=%b want sec=1 done=0", sec_o, done);
    end
    do_ticks(1);
    n_vec++;
    if ({hour_o, min_o, sec_o, done, running} !== {17'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL expire_hit got %0d:%0d:%0d done=%b run=%b want 0:0:0 done=1 run=0",
                        hour_o, min_o, sec_o, done, running);
    end
    n_vec++;
    if (alarm !== ALARM_ON_EXPIRE) begin
      n_err++; $display("FAIL expire_alarm got %b want %b", alarm, ALARM_ON_EXPIRE);
    end
    pulses = 0;
    tick = 1'b1;
    repeat (4) begin
      step();
      if (done) pulses++;
    end
    tick = 1'b0;
    n_vec++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL done_single got %0d extra pulses want 0", pulses);
    end
    n_vec++;
    if ({hour_o, min_o, sec_o, running} !== {17'd0, 1'b0}) begin
      n_err++; $display("FAIL expire_hold got %0d:%0d:%0d run=%b want 0:0:0 run=0", hour_o, min_o, sec_o, running);
    end
    n_vec++;
    if (alarm !== ALARM_ON_EXPIRE) begin
      n_err++; $display("FAIL alarm_held got %b want %b", alarm, ALARM_ON_EXPIRE);
    end
    do_stop();
    n_vec++;
    if ({alarm, running, done} !== 3'b000) begin
      n_err++; $display("FAIL expire_ack got alarm/run/done=%b want 000", {alarm, running, done});
    end
    // Back in IDLE on a zero count: start must be refused.
    do_start();
    n_vec++;
    if ({running, done} !== 2'b00) begin
      n_err++; $display("FAIL restart_zero got run/done=%b want 00", {running, done});
    end
  endtask

  task automatic test_hour_borrow();
    do_load(5'd1, 6'd0, 6'd0);
    do_start();
    do_ticks(1);
    n_vec++;
    if ({hour_o, min_o, sec_o, done} !== {5'd0, 6'd59, 6'd59, 1'b0}) begin
      n_err++; $display("FAIL hour_borrow got %0d:%0d:%0d done=%b want 0:59:59 done=0", hour_o, min_o, sec_o, done);
    end
  endtask

  task automatic test_priority();
    do_load(5'd0, 6'd0, 6'd10);
    do_start();
    do_ticks(1);
    n_vec++;
    if (sec_o !== 6'd9) begin
      n_err++; $display("FAIL prio_setup got sec=%0d want 9", sec_o);
    end
    hour_in = 5'd0; min_in = 6'd0; sec_in = 6'd5;
    load = 1'b1; stop = 1'b1; tick = 1'b1;
    step();
    load = 1'b0; stop = 1'b0; tick = 1'b0;
    n_vec++;
    if ({hour_o, min_o, sec_o, running} !== {5'd0, 6'd0, 6'd5, 1'b0}) begin
      n_err++; $display("FAIL prio_load got %0d:%0d:%0d run=%b want 0:0:5 run=0", hour_o, min_o, sec_o, running);
    end
    do_ticks(2);
    n_vec++;
    if (sec_o !== 6'd5) begin
      n_err++; $display("FAIL idle_tick got sec=%0d want 5", sec_o);
    end
  endtask

  task automatic test_pause();
    do_load(5'd0, 6'd0, 6'd3);
    do_start();
    do_ticks(1);
    do_stop();
    n_vec++;
    if ({sec_o, running} !== {6'd2, 1'b0}) begin
      n_err++; $display("FAIL pause got sec=%0d run=%b want sec=2 run=0", sec_o, running);
    end
    do_ticks(3);
    n_vec++;
    if (sec_o !== 6'd2) begin
      n_err++; $display("FAIL pause_tick got sec=%0d want 2", sec_o);
    end
    do_start();
    do_ticks(1);
    n_vec++;
    if ({sec_o, running} !== {6'd1, 1'b1}) begin
      n_err++; $display("FAIL resume got sec=%0d run=%b want sec=1 run=1", sec_o, running);
    end
  endtask

  task automatic test_clamp();
    do_load(5'd31, 6'd63, 6'd63);
    n_vec++;
    if ({hour_o, min_o, sec_o} !== {5'd23, 6'd59, 6'd59}) begin
      n_err++; $display("FAIL clamp_all got %0d:%0d:%0d want 23:59:59", hour_o, min_o, sec_o);
    end
    do_load(5'd0, 6'd0, 6'd63);
    do_start();
    n_vec++;
    if ({hour_o, min_o, sec_o, running} !== {5'd0, 6'd0, 6'd59, 1'b1}) begin
      n_err++; $display("FAIL clamp_sec got %0d:%0d:%0d run=%b want 0:0:59 run=1", hour_o, min_o, sec_o, running);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    do_load(5'd0, 6'd0, 6'd2);
    do_start();
    do_ticks(1);
    n_vec++;
    if ({sec_o, running} !== {6'd1, 1'b1}) begin
      n_err++; $display("FAIL rst_setup got sec=%0d run=%b want sec=1 run=1", sec_o, running);
    end
    // Assert reset between edges: outputs must clear without waiting for a clock.
    #2;
    rst_n = 1'b0;
    tick = 1'b1;
    #1;
    n_vec++;
    if ({hour_o, min_o, sec_o, running, done, alarm} !== 20'd0) begin
      n_err++; $display("FAIL async_rst got %0d:%0d:%0d run/done/alarm=%b want all 0",
                        hour_o, min_o, sec_o, {running, done, alarm});
    end
    pulses = 0;
    repeat (3) begin
      step();
      if (done) pulses++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      step();
      if (done) pulses++;
    end
    tick = 1'b0;
    n_vec++;
    if (pulses !== 0 || {hour_o, min_o, sec_o, running} !== 18'd0) begin
      n_err++; $display("FAIL rst_no_done got pulses=%0d count=%0d:%0d:%0d run=%b want 0 and 0:0:0 run=0",
                        pulses, hour_o, min_o, sec_o, running);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_sec_borrow();
    test_expire();
    test_hour_borrow();
    test_priority();
    test_pause();
    test_clamp();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter SEC_LIMIT, default 60: seconds modulus.
REQ-002 SHALL have parameter MIN_LIMIT, default 60: minutes modulus.
REQ-003 SHALL have parameter HOUR_LIMIT, default 24: hours modulus.
REQ-004 SHALL have port iClk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port iRst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port iTick, input, 1 bit: one-cycle count-enable strobe (1 Hz in system).
REQ-007 SHALL have port iLoad, input, 1 bit: load iHour/iMin/iSec into count.
REQ-008 SHALL have ports iSec and iMin, input, 6 bits each; iHour, input, 5 bits: load values.
REQ-009 SHALL have ports iStart and iStop, input, 1 bit each: run and pause/acknowledge requests.
REQ-010 SHALL have ports oSec and oMin, output, 6 bits each; oHour, output, 5 bits: current registered count.
REQ-011 SHALL have port oRunning, output, 1 bit: high in RUN.
REQ-012 SHALL have port oDone, output, 1 bit: one-cycle pulse at expiry.
REQ-013 SHALL have port oAlarm, output, 1 bit: latched expiry indication (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, EXPIRED.
REQ-015 SHALL apply same-cycle request priority iLoad > iStop > iStart > iTick.
REQ-016 SHALL, on iLoad in any state, load the count and go to IDLE, clamping each field >= its LIMIT to LIMIT-1.
REQ-017 SHALL, on iStart in IDLE or PAUSE with nonzero count, go to RUN; with a zero count, stay put with no oDone.
REQ-018 SHALL, on iStop in RUN, go to PAUSE with the count held; on iStop in EXPIRED, go to IDLE.
REQ-019 SHALL ignore iStart in RUN and EXPIRED, and iStop in IDLE and PAUSE.
REQ-020 SHALL, on iTick in RUN, decrement seconds; seconds 0 borrows: sec=SEC_LIMIT-1, minutes decrement; minutes 0 with borrow: min=MIN_LIMIT-1, hours decrement.
REQ-021 SHALL, when an iTick in RUN brings the count to 00:00:00, go to EXPIRED and pulse oDone on the next cycle, exactly once.
REQ-022 SHALL never decrement below 00:00:00 or wrap from zero.
REQ-023 SHALL ignore iTick outside RUN.
REQ-024 SHALL register all outputs, with a count update visible the cycle after the iTick edge.
REQ-025 SHALL accept an iTick held high for N cycles as N decrements.

Reset
REQ-026 SHALL, while iRst=0, asynchronously force state IDLE, count 00:00:00, oRunning=0, oDone=0 and oAlarm=0.
REQ-027 SHALL, on reset mid-RUN, discard the count and produce no oDone.

Configuration
REQ-028 SHALL, with macro COUNTDOWN_ALARM_EN defined, set oAlarm on entry to EXPIRED and hold it until iLoad, iStop or reset.
REQ-029 SHALL, without COUNTDOWN_ALARM_EN, keep port oAlarm and drive it constant 0.

Structure
REQ-030 SHALL place the state enum typedef and the default limit constants in shared package clock_pkg.
REQ-031 SHALL instantiate per field one DownCounter sub-module (parameter LIMIT; inputs iClk, iRst, iEn, iLoad, iValue; outputs oValue, oBorrow, oZero), chaining oBorrow into the next iEn.

Verification
REQ-032 SHALL cover: load 00:01:05, start, 6 ticks -> 00:00:59 after the 6th tick, oRunning=1.
REQ-033 SHALL cover: load 00:00:02, start, 2 ticks -> 00:00:00, EXPIRED, oDone high exactly 1 cycle; extra ticks leave the count at 0.
REQ-034 SHALL cover: load 01:00:00, start, 1 tick -> 00:59:59.
REQ-035 SHALL cover: iLoad, iStop and iTick asserted together in RUN -> load wins, IDLE, no decrement.
REQ-036 SHALL cover: load 00:00:00 with iSec=63, start -> count 00:00:59 (clamped), enters RUN.
REQ-037 SHALL cover: iRst low mid-RUN at 00:00:01 -> all outputs 0 asynchronously, no oDone; with COUNTDOWN_ALARM_EN, expiry sets oAlarm until iStop.
